// File: rtl/mmc1_ext_pkg.sv
// Shared constants and encodings for the MMC1 mapper and its serial loader.
package mmc1_ext_pkg;

    // Cartridge board variants, which decide how CHR bank bits are reused.
    typedef enum logic [1:0] {
        BOARD_SNROM = 2'd0,
        BOARD_SOROM = 2'd1,
        BOARD_SUROM = 2'd2,
        BOARD_SXROM = 2'd3
    } board_t;

    // Internal register picked by CPU address bits 14:13 on the fifth serial write.
    typedef enum logic [1:0] {
        SEL_CONTROL = 2'd0,
        SEL_CHR0    = 2'd1,
        SEL_CHR1    = 2'd2,
        SEL_PRG     = 2'd3
    } reg_sel_t;

    // CHR space lives at 2 MB and WRAM near the top of the 4 MB linear space.
    localparam logic [21:0] CHR_BASE      = 22'h200000;
    localparam logic [21:0] WRAM_BASE     = 22'h3C0000;
    localparam logic [4:0]  CONTROL_RESET = 5'b01100;

endpackage

// File: rtl/mmc1_ext_serial.sv
// Five-write serial shifter with the back-to-back write filter.
import mmc1_ext_pkg::*;

module mmc1_serial_loader (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       prg_write,
    input  logic [2:0] addr_hi,
    input  logic       din_bit,
    input  logic       din_reset,
    output logic       commit,
    output logic       ctrl_reset,
    output reg_sel_t   target,
    output logic [4:0] data,
    output logic [2:0] load_cnt
);

    logic [3:0] shift;
    logic       prev_write;
    logic       hit;
    logic       accept;

    // Decode this cycle's write; a write right after another $8000+ write is dropped.
    always_comb begin
        hit        = prg_write && addr_hi[2];
        accept     = ce && hit && !prev_write;
        ctrl_reset = accept && din_reset;
        commit     = accept && !din_reset && (load_cnt == 3'd4);
        target     = reg_sel_t'(addr_hi[1:0]);
        data       = {din_bit, shift};
    end

    // Shift register, bit counter and filter flag advance only on enabled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift      <= 4'h0;
            load_cnt   <= 3'd0;
            prev_write <= 1'b0;
        end else if (ce) begin
            prev_write <= hit;
            if (ctrl_reset || commit) begin
                shift    <= 4'h0;
                load_cnt <= 3'd0;
            end else if (accept) begin
                shift    <= {din_bit, shift[3:1]};
                load_cnt <= load_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/mmc1_ext.sv
// MMC1 mapper: serial-loaded bank registers plus PRG/WRAM/CHR address mapping.
import mmc1_ext_pkg::*;

module mmc1_ext #(
    parameter int PRG_OUTER_W = 1,
    parameter int WRAM_BANK_W = 2,
    parameter int REV         = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [1:0]  board,
    input  logic        chr_ram,
    input  logic [15:0] prg_ain,
    input  logic        prg_write,
    input  logic [7:0]  prg_din,
    output logic [21:0] prg_aout,
    output logic        prg_allow,
    output logic        wram_en,
    input  logic [13:0] chr_ain,
    output logic [21:0] chr_aout,
    output logic        chr_allow,
    output logic        vram_a10,
    output logic        vram_ce,
    output logic        load_busy,
    output logic [2:0]  load_cnt
);

    localparam int          OUTER_SHIFT = 2 - PRG_OUTER_W;
    localparam logic [1:0]  WRAM_MASK   = 2'((1 << WRAM_BANK_W) - 1);

    logic [4:0] control;
    logic [4:0] chr0;
    logic [4:0] chr1;
    logic [4:0] prg;
    logic       commit;
    logic       ctrl_reset;
    reg_sel_t   target;
    logic [4:0] data;
    board_t     brd;
    logic       big_board;
    logic       wram_win;
    logic [4:0] outer_src;
    logic [1:0] outer_top;
    logic [1:0] outer;
    logic [3:0] inner;
    logic [1:0] wram_bank;
    logic [4:0] chrsel;
    logic       din_unused;

    assign din_unused = ^prg_din[6:1];

    mmc1_serial_loader u_loader (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .prg_write  (prg_write),
        .addr_hi    (prg_ain[15:13]),
        .din_bit    (prg_din[0]),
        .din_reset  (prg_din[7]),
        .commit     (commit),
        .ctrl_reset (ctrl_reset),
        .target     (target),
        .data       (data),
        .load_cnt   (load_cnt)
    );

    // Bank registers take the completed serial value, or force fixed-$C000 mode on a loader reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            control <= CONTROL_RESET;
            chr0    <= 5'h00;
            chr1    <= 5'h00;
            prg     <= 5'h00;
        end else if (commit) begin
            case (target)
                SEL_CONTROL: control <= data;
                SEL_CHR0:    chr0    <= data;
                SEL_CHR1:    chr1    <= data;
                default:     prg     <= data;
            endcase
        end else if (ctrl_reset) begin
            control[3:2] <= 2'b11;
        end
    end

    // CPU side: ROM banking with board-dependent outer bits, or the banked WRAM window.
    always_comb begin
        brd       = board_t'(board);
        big_board = (brd == BOARD_SUROM) || (brd == BOARD_SXROM);
        wram_win  = (prg_ain[15:13] == 3'b011);
        outer_src = (control[4] && chr_ain[12]) ? chr1 : chr0;
        outer_top = outer_src[4:3];
        outer     = big_board ? (outer_top >> OUTER_SHIFT) : 2'b00;
        case (control[3:2])
            2'b10:   inner = prg_ain[14] ? prg[3:0] : 4'h0;
            2'b11:   inner = prg_ain[14] ? 4'hF : prg[3:0];
            default: inner = {prg[3:1], prg_ain[14]};
        endcase
        case (brd)
            BOARD_SXROM: wram_bank = chr0[3:2];
            BOARD_SOROM: wram_bank = {1'b0, chr0[3]};
            default:     wram_bank = 2'b00;
        endcase
        wram_bank = wram_bank & WRAM_MASK;
        wram_en   = !((REV != 0) && prg[4]);
        prg_allow = (prg_ain[15] && !prg_write) || (wram_win && wram_en);
        if (wram_win) begin
            prg_aout = WRAM_BASE | {7'b0, wram_bank, prg_ain[12:0]};
        end else begin
            prg_aout = {2'b00, outer, inner, prg_ain[13:0]};
        end
    end

    // PPU side: 4 KB CHR banking and nametable mirroring.
    always_comb begin
        chrsel = control[4] ? (chr_ain[12] ? chr1 : chr0) : {chr0[4:1], chr_ain[12]};
        if (big_board) begin
            chrsel[4] = 1'b0;
        end
        chr_aout = CHR_BASE | {5'b0, chrsel, chr_ain[11:0]};
        case (control[1:0])
            2'd0:    vram_a10 = 1'b0;
            2'd1:    vram_a10 = 1'b1;
            2'd2:    vram_a10 = chr_ain[10];
            default: vram_a10 = chr_ain[11];
        endcase
    end

    assign chr_allow = chr_ram;
    assign vram_ce   = chr_ain[13];
    assign load_busy = (load_cnt != 3'd0);

endmodule

// File: tb/tb_mmc1_ext.sv
// Directed and random checks of mmc1_ext against an arithmetic mapper model.
module tb_mmc1_ext;

    localparam int PW = 1;
    localparam int WB = 2;

    logic        clk = 1'b0;
    logic        reset, ce, chr_ram, prg_write;
    logic [1:0]  board;
    logic [15:0] prg_ain;
    logic [7:0]  prg_din;
    logic [13:0] chr_ain;
    logic [21:0] prg_aout, chr_aout, a_prg_aout, a_chr_aout;
    logic        prg_allow, wram_en, chr_allow, vram_a10, vram_ce, load_busy;
    logic        a_prg_allow, a_wram_en, a_chr_allow, a_vram_a10, a_vram_ce, a_load_busy;
    logic [2:0]  load_cnt, a_load_cnt;

    int tests = 0;
    int fails = 0;

    int m_ctrl, m_chr0, m_chr1, m_prg;
    bit m_prev;
    bit bits[$];

    always #5 clk = ~clk;

    mmc1_ext #(.PRG_OUTER_W(PW), .WRAM_BANK_W(WB), .REV(1)) dut (
        .clk(clk), .reset(reset), .ce(ce), .board(board), .chr_ram(chr_ram),
        .prg_ain(prg_ain), .prg_write(prg_write), .prg_din(prg_din),
        .prg_aout(prg_aout), .prg_allow(prg_allow), .wram_en(wram_en),
        .chr_ain(chr_ain), .chr_aout(chr_aout), .chr_allow(chr_allow),
        .vram_a10(vram_a10), .vram_ce(vram_ce),
        .load_busy(load_busy), .load_cnt(load_cnt)
    );

    mmc1_ext #(.PRG_OUTER_W(PW), .WRAM_BANK_W(WB), .REV(0)) dut_a (
        .clk(clk), .reset(reset), .ce(ce), .board(board), .chr_ram(chr_ram),
        .prg_ain(prg_ain), .prg_write(prg_write), .prg_din(prg_din),
        .prg_aout(a_prg_aout), .prg_allow(a_prg_allow), .wram_en(a_wram_en),
        .chr_ain(chr_ain), .chr_aout(a_chr_aout), .chr_allow(a_chr_allow),
        .vram_a10(a_vram_a10), .vram_ce(a_vram_ce),
        .load_busy(a_load_busy), .load_cnt(a_load_cnt)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: five bits collected in a queue, value built by weighted sum.
    task automatic modelStep();
        bit hit;
        int v;
        int a;
        a = int'(prg_ain);
        if (reset) begin
            m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
            m_prev = 0;
            bits.delete();
        end else if (ce) begin
            hit = prg_write && (a >= 32768);
            if (hit && !m_prev) begin
                if (prg_din >= 8'h80) begin
                    bits.delete();
                    m_ctrl = m_ctrl | 12;
                end else begin
                    bits.push_back(prg_din[0]);
                    if (bits.size() == 5) begin
                        v = 0;
                        for (int i = 0; i < 5; i++) v += int'(bits[i]) * (1 << i);
                        case ((a - 32768) / 8192)
                            0: m_ctrl = v;
                            1: m_chr0 = v;
                            2: m_chr1 = v;
                            default: m_prg = v;
                        endcase
                        bits.delete();
                    end
                end
            end
            m_prev = hit;
        end
    endtask

    task automatic checkOutput();
        int a, ca, a14, a12, mode, inner, src, outer, bank, exp_prg, sel, mir, a10;
        bit win, wen, allow, allow_a;
        a = int'(prg_ain);
        ca = int'(chr_ain);
        a14 = (a / 16384) % 2;
        a12 = (ca / 4096) % 2;
        mode = (m_ctrl / 4) % 4;
        if (mode < 2) inner = ((m_prg % 16) / 2) * 2 + a14;
        else if (mode == 2) inner = a14 ? m_prg % 16 : 0;
        else inner = a14 ? 15 : m_prg % 16;
        src = (m_ctrl >= 16 && a12 == 1) ? m_chr1 : m_chr0;
        outer = (board >= 2) ? (src >> (5 - PW)) : 0;
        win = (a >= 24576) && (a < 32768);
        if (board == 3) bank = (m_chr0 / 4) % 4;
        else if (board == 1) bank = (m_chr0 / 8) % 2;
        else bank = 0;
        bank = bank % (1 << WB);
        exp_prg = win ? 'h3C0000 + bank * 8192 + a % 8192
                      : outer * 262144 + inner * 16384 + a % 16384;
        wen = !(m_prg >= 16);
        allow = (a >= 32768 && !prg_write) || (win && wen);
        allow_a = (a >= 32768 && !prg_write) || win;
        sel = (m_ctrl < 16) ? (m_chr0 / 2) * 2 + a12 : (a12 ? m_chr1 : m_chr0);
        if (board >= 2) sel = sel % 16;
        mir = m_ctrl % 4;
        a10 = (mir == 0) ? 0 : (mir == 1) ? 1 : (mir == 2) ? (ca / 1024) % 2 : (ca / 2048) % 2;
        checkVal("prg_aout", 32'(prg_aout), exp_prg);
        checkVal("prg_allow", 32'(prg_allow), 32'(allow));
        checkVal("wram_en", 32'(wram_en), 32'(wen));
        checkVal("chr_aout", 32'(chr_aout), 'h200000 + sel * 4096 + ca % 4096);
        checkVal("chr_allow", 32'(chr_allow), 32'(chr_ram));
        checkVal("vram_a10", 32'(vram_a10), a10);
        checkVal("vram_ce", 32'(vram_ce), (ca / 8192) % 2);
        checkVal("load_cnt", 32'(load_cnt), bits.size());
        checkVal("load_busy", 32'(load_busy), 32'(bits.size() != 0));
        checkVal("revA_wram_en", 32'(a_wram_en), 1);
        checkVal("revA_prg_allow", 32'(a_prg_allow), 32'(allow_a));
    endtask

    task automatic applyStimulus(input logic r, input logic c, input logic w,
                                 input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        reset = r; ce = c; prg_write = w; prg_ain = a; prg_din = d;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic writeSerial(input logic [15:0] a, input logic [4:0] val);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, a, {7'b0, val[i]});
            applyStimulus(1'b0, 1'b1, 1'b0, a, 8'h00);
        end
    endtask

    initial begin
        board = 2'd0; chr_ram = 1'b0; chr_ain = 14'h0;
        reset = 1'b1; ce = 1'b0; prg_write = 1'b0; prg_ain = 16'h0; prg_din = 8'h0;

        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
        checkVal("rst_prg_aout", 32'(prg_aout), 0);
        checkVal("rst_load_busy", 32'(load_busy), 0);
        checkVal("rst_wram_en", 32'(wram_en), 1);
        checkVal("rst_vram_a10", 32'(vram_a10), 0);
        checkVal("rst_chr_aout", 32'(chr_aout), 'h200000);

        writeSerial(16'hE000, 5'h05);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h8000, 8'h00);
        checkVal("prg_bank_5", 32'(prg_aout[17:14]), 5);

        applyStimulus(1'b0, 1'b1, 1'b1, 16'h8000, 8'h01);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h8000, 8'h01);
        checkVal("filter_cnt", 32'(load_cnt), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h8000, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h8000, 8'h80);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h8000, 8'h00);

        writeSerial(16'hA000, 5'h06);
        writeSerial(16'h8000, 5'h00);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 16'h8000, 8'h01);
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h8000, 8'h00);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h8000, 8'h80);
        checkVal("din80_cnt", 32'(load_cnt), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'hC000, 8'h00);
        checkVal("din80_mode", 32'(prg_aout[17:14]), 15);
        checkVal("din80_chr0", 32'(chr_aout), 'h206000);

        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 8'h00);
        board = 2'd2;
        writeSerial(16'hA000, 5'h10);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'hC000, 8'h00);
        checkVal("surom_outer", 32'(prg_aout), 'h07C000);

        board = 2'd3;
        writeSerial(16'hA000, 5'h0C);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h6000, 8'h00);
        checkVal("sxrom_wram", 32'(prg_aout), 'h3C6000);
        writeSerial(16'hE000, 5'h10);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h6000, 8'h00);
        checkVal("wram_disable", 32'(wram_en), 0);
        checkVal("wram_allow", 32'(prg_allow), 0);
        checkVal("revA_allow", 32'(a_prg_allow), 1);

        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h8000, 8'h01);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h8000, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h8000, 8'h01);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h8000, 8'h00);
        checkVal("midload_rst_cnt", 32'(load_cnt), 0);
        writeSerial(16'hE000, 5'h0A);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h8000, 8'h00);
        checkVal("after_rst_commit", 32'(prg_aout), 'h028000);

        for (int n = 0; n < 400; n++) begin
            logic r, c, w;
            logic [15:0] a;
            logic [7:0] d;
            board   = 2'($urandom);
            chr_ain = 14'($urandom);
            chr_ram = 1'($urandom);
            r = ($urandom_range(0, 63) == 0);
            c = ($urandom_range(0, 3) != 0);
            w = 1'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : (16'h8000 | 16'($urandom));
            d = ($urandom_range(0, 15) == 0) ? 8'h80 : 8'($urandom_range(0, 1));
            applyStimulus(r, c, w, a, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mmc1_ext.md
MMC1_EXT -- requirements
Module: mmc1_ext

Interface
REQ-001 SHALL have parameter PRG_OUTER_W, default 1, meaning the number of 256 KB outer PRG bank bits taken from the CHR bank register (0..2).
REQ-002 SHALL have parameter WRAM_BANK_W, default 2, meaning the number of 8 KB WRAM bank-select bits (0..2).
REQ-003 SHALL have parameter REV, default 1, meaning 0 = MMC1A (prg_bank[4] WRAM disable ignored) and 1 = MMC1B (disable honoured).
REQ-004 SHALL have ports: clk  in  1  system clock; reset  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: ce  in  1  M2 cycle enable; board  in  2  0 = SNROM, 1 = SOROM, 2 = SUROM, 3 = SXROM; chr_ram  in  1  CHR writable.
REQ-006 SHALL have ports: prg_ain  in  16  CPU address; prg_write  in  1  CPU write; prg_din  in  8  CPU data.
REQ-007 SHALL have ports: prg_aout  out  22  linear PRG address; prg_allow  out  1  PRG access permitted; wram_en  out  1  WRAM enabled.
REQ-008 SHALL have ports: chr_ain  in  14  PPU address; chr_aout  out  22  linear CHR address; chr_allow  out  1  CHR write allowed; vram_a10  out  1  CIRAM A10; vram_ce  out  1  CIRAM select.
REQ-009 SHALL have ports: load_busy  out  1  serial load in progress; load_cnt  out  3  bits shifted so far.
REQ-010 SHALL have the decided property that it uses one clock (clk) and that reset is synchronous and active-high.

Function
REQ-011 SHALL update state only on clk edges where ce=1, except reset.
REQ-012 SHALL accept a serial write when prg_write=1, prg_ain[15]=1, and the previous ce cycle carried no accepted-or-ignored $8000+ write; the consecutive-cycle filter flag SHALL be registered each ce cycle.
REQ-013 SHALL, on an accepted write with prg_din[7]=1, clear load_cnt to 0, clear the shift data, and set control[3:2]=2'b11 while keeping control[4] and control[1:0].
REQ-014 SHALL, on an accepted write with din[7]=0 and load_cnt<4, shift din[0] into the MSB of a 4-bit shift register and increment load_cnt.
REQ-015 SHALL, on an accepted write with din[7]=0 and load_cnt=4, commit {din[0], shift[3:0]} to the register selected by prg_ain[14:13] (control, chr0, chr1, prg), and clear load_cnt and shift in the same cycle.
REQ-016 SHALL drive load_busy = (load_cnt != 0).
REQ-017 SHALL select the 16 KB inner PRG bank per control[3:2]: 0x = {prg[3:1], ain[14]}; 10 = 0 at $8000 and prg[3:0] at $C000; 11 = prg[3:0] at $8000 and 4'hF at $C000.
REQ-018 SHALL, for board 2 and 3, form the outer PRG bits from chr0[4 -: PRG_OUTER_W], and otherwise set them to 0; in CHR 4 KB mode the outer bits SHALL be taken from chr1 when chr_ain[12]=1.
REQ-019 SHALL map ROM as prg_aout = {zero-pad, outer, inner, prg_ain[13:0]}.
REQ-020 SHALL, for $6000-$7FFF, drive prg_aout = 22'h3C0000 | {wram_bank, prg_ain[12:0]}, where wram_bank comes from chr0[3:2] on SXROM, from chr0[3] on SOROM, and is 0 otherwise, truncated to WRAM_BANK_W.
REQ-021 SHALL drive wram_en = !(REV && prg[4]).
REQ-022 SHALL drive prg_allow = (ain[15] && !prg_write) || (WRAM window && wram_en).
REQ-023 SHALL select CHR in 4 KB units: control[4]=0 gives {chr0[4:1], chr_ain[12]}; otherwise chr0 or chr1 by chr_ain[12].
REQ-024 SHALL set chr_aout = 22'h200000 | {chrsel, chr_ain[11:0]}, with chrsel[4] forced to 0 on boards 2 and 3.
REQ-025 SHALL drive chr_allow = chr_ram, vram_ce = chr_ain[13], and vram_a10 per control[1:0] (0 gives 0, 1 gives 1, 2 gives chr_ain[10], 3 gives chr_ain[11]).
REQ-026 SHALL compute all address outputs combinationally from registers, so that a committed register is visible one clk after the committing edge.
REQ-027 SHALL ignore writes below $8000 for serial loading.

Reset
REQ-028 SHALL, when reset=1, set control=5'b01100, chr0=0, chr1=0, prg=0, shift=0, load_cnt=0, and the filter flag=0, regardless of ce.
REQ-029 SHALL let reset asserted mid-load discard the partial value, with no register changing.
REQ-030 SHALL produce the following reset outputs, with ain=0 and chr_ain=0: prg_aout=0, load_busy=0, wram_en=1, vram_a10=0, and chr_aout=22'h200000.

Structure
REQ-031 SHALL place board encodings, the register-select encoding, and the base constants 22'h200000 and 22'h3C0000 in the shared mapper package.
REQ-032 SHALL implement serial loading and the consecutive-write filter in the sub-module mmc1_serial_loader, which outputs a commit strobe, a 2-bit target, and 5-bit data.

Verification
REQ-033 SHALL verify that five accepted writes to $E000 with din bit0 = 1,0,1,0,0 give prg=5'h05, and that a read at $8000 gives prg_aout[17:14]=5 with control mode 3.
REQ-034 SHALL verify that a write to $8000 on two consecutive ce cycles advances load_cnt by 1 only.
REQ-035 SHALL verify that a write of din=8'h80 after 3 bits gives load_cnt=0 and control[3:2]=3, with chr0 unchanged.
REQ-036 SHALL verify that SUROM with chr0=5'h10 and control=5'h0C gives prg_aout=22'h07C000 on a read of $C000.
REQ-037 SHALL verify that SXROM with chr0=5'h0C and REV=1 gives prg_aout=22'h3C6000 for $6000; that prg=5'h10 then drives wram_en=0 and prg_allow=0; and that REV=0 keeps prg_allow=1.
REQ-038 SHALL verify that reset asserted after 2 bits shifted leaves load_cnt=0, and that 5 fresh writes then commit correctly.
